// File: rtl/ram_param_fill.sv
// Single-port synchronous RAM with registered write-first reads and a fill sequencer.
// A fill runs after every reset and on request, so no uninitialised word is ever read.
module ram_param_fill #(
  parameter int unsigned          DATA_WIDTH    = 16,
  parameter int unsigned          ADDRESS_WIDTH = 9,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE   = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0]    in,
  input  logic                     load,
  output logic [DATA_WIDTH-1:0]    out,
  input  logic                     fill_start,
  input  logic [DATA_WIDTH-1:0]    fill_value,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] LastAddr = '1;

  typedef enum logic {StIdle, StFill} state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] fill_addr_q, fill_addr_d;
  logic [DATA_WIDTH-1:0]    fill_data_q, fill_data_d;
  logic [DATA_WIDTH-1:0]    out_q, out_d;
  logic                     done_q, done_d;

  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [DATA_WIDTH-1:0]    mem [DEPTH];

  // State register; reset lands in StFill so the post-reset fill starts at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFill;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (fill_start) state_d = StFill;
      StFill: if (fill_addr_q == LastAddr) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state and memory write port; fill_start beats load in idle.
  always_comb begin
    fill_addr_d = fill_addr_q;
    fill_data_d = fill_data_q;
    out_d       = out_q;
    done_d      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = address;
    mem_wdata   = in;
    unique case (state_q)
      StFill: begin
        mem_we      = 1'b1;
        mem_addr    = fill_addr_q;
        mem_wdata   = fill_data_q;
        fill_addr_d = fill_addr_q + 1'b1;
        out_d       = '0;
        done_d      = (fill_addr_q == LastAddr);
      end
      StIdle: begin
        if (fill_start) begin
          fill_addr_d = '0;
          fill_data_d = fill_value;
          out_d       = '0;
        end else if (load) begin
          mem_we = 1'b1;
          out_d  = in;
        end else begin
          out_d = mem[address];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_addr_q <= '0;
      fill_data_q <= FILL_VALUE;
      out_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      fill_addr_q <= fill_addr_d;
      fill_data_q <= fill_data_d;
      out_q       <= out_d;
      done_q      <= done_d;
    end
  end

  // Memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  always_comb begin
    busy = (state_q == StFill);
    done = done_q;
    out  = out_q;
  end

endmodule

// File: tb/tb_ram_param_fill.sv
// Bench for ram_param_fill: a per-cycle reference model checks the default instance every
// cycle, directed literals pin the model, and a small second instance covers overrides.
module tb_ram_param_fill;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [8:0]  address;
  logic [15:0] in;
  logic        load;
  logic [15:0] out;
  logic        fill_start;
  logic [15:0] fill_value;
  logic        busy;
  logic        done;

  logic        rst8_n;
  logic [2:0]  address8;
  logic [7:0]  in8;
  logic        load8;
  logic [7:0]  out8;
  logic        fill_start8;
  logic [7:0]  fill_value8;
  logic        busy8;
  logic        done8;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  ram_param_fill dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .address    (address),
    .in         (in),
    .load       (load),
    .out        (out),
    .fill_start (fill_start),
    .fill_value (fill_value),
    .busy       (busy),
    .done       (done)
  );

  ram_param_fill #(
    .DATA_WIDTH    (8),
    .ADDRESS_WIDTH (3),
    .FILL_VALUE    (8'h3C)
  ) dut8 (
    .clk        (clk),
    .rst_n      (rst8_n),
    .address    (address8),
    .in         (in8),
    .load       (load8),
    .out        (out8),
    .fill_start (fill_start8),
    .fill_value (fill_value8),
    .busy       (busy8),
    .done       (done8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a fill is a run of 512 writes counted down; idle is a plain array.
  logic [15:0] mem_m [512];
  int          fill_left;
  int          fill_pos;
  logic [15:0] fill_word;
  logic [15:0] out_m;
  logic        done_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_left <= 512;
      fill_pos  <= 0;
      fill_word <= 16'h0000;
      out_m     <= 16'h0000;
      done_m    <= 1'b0;
    end else if (fill_left > 0) begin
      mem_m[fill_pos[8:0]] <= fill_word;
      fill_pos  <= fill_pos + 1;
      fill_left <= fill_left - 1;
      out_m     <= 16'h0000;
      done_m    <= (fill_left == 1);
    end else begin
      done_m <= 1'b0;
      if (fill_start) begin
        fill_left <= 512;
        fill_pos  <= 0;
        fill_word <= fill_value;
        out_m     <= 16'h0000;
      end else if (load) begin
        mem_m[address] <= in;
        out_m          <= in;
      end else begin
        out_m <= mem_m[address];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", {31'd0, busy}, {31'd0, fill_left > 0});
      check("model_done", {31'd0, done}, {31'd0, done_m});
      check("model_out", {16'd0, out}, {16'd0, out_m});
    end
  end

  task automatic wait_fill(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 5000) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic read_word(input logic [8:0] a, input logic [15:0] exp, input string nm);
    address = a;
    load    = 1'b0;
    @(negedge clk);
    check(nm, {16'd0, out}, {16'd0, exp});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish, expected finish before 2ms");
    $fatal(1, "timeout");
  end

  initial begin
    int          cnt;
    logic [15:0] w;
    rst_n = 1'b0;  address = '0; in = '0; load = 1'b0; fill_start = 1'b0; fill_value = '0;
    rst8_n = 1'b0; address8 = '0; in8 = '0; load8 = 1'b0; fill_start8 = 1'b0; fill_value8 = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_out", {16'd0, out}, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'h1);
    check("reset_done", {31'd0, done}, 32'h0);

    // 1: post-reset fill with zeros
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_fill(cnt);
    check("t1_busy_cycles", cnt, 512);
    check("t1_done_pulse", {31'd0, done}, 32'h1);
    @(negedge clk);
    check("t1_done_low", {31'd0, done}, 32'h0);
    check("t1_idle", {31'd0, busy}, 32'h0);
    for (int i = 0; i < 512; i++) read_word(9'(i), 16'h0000, "t1_read");

    // 2: write/read ramp
    for (int i = 0; i < 512; i++) begin
      w       = 16'h5A5A + 16'(i);
      address = 9'(i);
      in      = w;
      load    = 1'b1;
      @(negedge clk);
    end
    load = 1'b0;
    for (int i = 0; i < 512; i++) begin
      w = 16'h5A5A + 16'(i);
      read_word(9'(i), w, "t2_read");
    end
    read_word(9'd511, 16'h5C59, "t2_last");

    // 3: write-first bypass
    address = 9'h0A5; in = 16'hBEEF; load = 1'b1;
    @(negedge clk);
    check("t3_bypass", {16'd0, out}, 32'hBEEF);
    load = 1'b0; in = 16'h0000;
    @(negedge clk);
    check("t3_reread", {16'd0, out}, 32'hBEEF);

    // 4: fill request wins over a concurrent load; requests during fill ignored
    fill_start = 1'b1; fill_value = 16'hA5A5; load = 1'b1; address = 9'd3; in = 16'h1234;
    @(negedge clk);
    fill_start = 1'b0; load = 1'b0;
    check("t4_busy_rise", {31'd0, busy}, 32'h1);
    check("t4_out_zero", {16'd0, out}, 32'h0);
    for (int j = 0; j < 3; j++) begin
      fill_start = 1'b1; fill_value = 16'h1111; load = 1'b1; address = 9'd5; in = 16'h9999;
      @(negedge clk);
    end
    fill_start = 1'b0; load = 1'b0;
    wait_fill(cnt);
    check("t4_fill_rest", cnt, 509);
    check("t4_done", {31'd0, done}, 32'h1);
    for (int i = 0; i < 512; i++) read_word(9'(i), 16'hA5A5, "t4_read");
    read_word(9'd3, 16'hA5A5, "t4_addr3");

    // 5: reset in the middle of a fill restarts with the default value
    fill_start = 1'b1; fill_value = 16'hFFFF;
    @(negedge clk);
    fill_start = 1'b0;
    repeat (99) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_out_reset", {16'd0, out}, 32'h0);
    check("t5_done_reset", {31'd0, done}, 32'h0);
    check("t5_busy_reset", {31'd0, busy}, 32'h1);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_fill(cnt);
    check("t5_busy_cycles", cnt, 512);
    check("t5_done", {31'd0, done}, 32'h1);
    for (int i = 0; i < 512; i++) read_word(9'(i), 16'h0000, "t5_read");

    // 6: overridden parameters
    @(negedge clk);
    #2 rst8_n = 1'b1;
    cnt = 0;
    while (busy8 === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("t6_busy_cycles", cnt, 8);
    check("t6_done", {31'd0, done8}, 32'h1);
    @(negedge clk);
    check("t6_done_low", {31'd0, done8}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      address8 = 3'(i);
      @(negedge clk);
      check("t6_read", {24'd0, out8}, 32'h3C);
    end
    address8 = 3'd7; in8 = 8'hFF; load8 = 1'b1;
    @(negedge clk);
    check("t6_bypass", {24'd0, out8}, 32'hFF);
    load8 = 1'b0;
    @(negedge clk);
    check("t6_reread", {24'd0, out8}, 32'hFF);
    address8 = 3'd0;
    @(negedge clk);
    check("t6_addr0", {24'd0, out8}, 32'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_param_fill.md
Name: ram_param_fill

Overview:
Parametrised single-port synchronous RAM with the same address/in/load/out interface as the existing RAM blocks, generalised in data width and depth. Adds a built-in fill sequencer that writes a known value to every word. The fill runs automatically after reset and again on request, so downstream logic never reads uninitialised memory. Reads are registered, with write-first bypass.

Parameters:
DATA_WIDTH, 16, word width in bits
ADDRESS_WIDTH, 9, address width; DEPTH = 2**ADDRESS_WIDTH words (derived, not overridable)
FILL_VALUE, 0, word written by the post-reset fill

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
address  input  ADDRESS_WIDTH  read/write address
in  input  DATA_WIDTH  write data
load  input  1  write enable; honoured only in IDLE
out  output  DATA_WIDTH  registered read data
fill_start  input  1  request a fill with fill_value; honoured only in IDLE
fill_value  input  DATA_WIDTH  fill word, sampled on the accepted fill_start
busy  output  1  high while a fill is in progress
done  output  1  one-cycle pulse after the last fill write

Behaviour:
- One clock (clk) and one asynchronous active-low reset (rst_n). Memory array is not reset.
- Reset values:
  - state = FILL, fill_addr = 0, fill_data = FILL_VALUE.
  - out = 0, busy = 1, done = 0.
- FSM states: IDLE, FILL. busy = (state == FILL), registered state.
- FILL, on each edge:
  - Write mem[fill_addr] = fill_data, then fill_addr += 1.
  - When fill_addr == DEPTH-1: write, then go to IDLE, set done = 1 for exactly one cycle, and wrap fill_addr to 0.
  - A fill is exactly DEPTH write cycles; busy is high for DEPTH cycles after reset release.
  - load ignored; fill_start ignored (no restart); out forced to 0.
- IDLE, on each edge:
  - load = 1: mem[address] = in.
  - out <= mem[address], 1-cycle read latency.
  - load = 1 with the same address: out <= in (write-first).
- fill_start = 1 in IDLE:
  - Next state FILL, fill_addr = 0, fill_data = fill_value.
  - If load is also 1 that cycle, fill_start wins and the write is dropped.
  - out <= 0 from that edge.
- done is high only on the cycle after the final fill write. done is 0 otherwise, including in reset.
- rst_n asserted mid-fill or mid-operation:
  - Immediately returns to the reset values.
  - After release, the fill restarts at address 0 with FILL_VALUE, not the last fill_value.
- Address range is always valid because DEPTH = 2**ADDRESS_WIDTH. fill_addr has ADDRESS_WIDTH bits and wraps naturally.
- No combinational path from inputs to out, busy or done.

Test Plan:
1. Defaults (16-bit, 9-bit address). Release rst_n -> busy = 1 for exactly 512 cycles, then done = 1 for exactly 1 cycle, then busy = 0. Read all 512 addresses -> every out = 16'h0000, one cycle after each address.
2. In IDLE, write in = 16'h5A5A + i to addresses i = 0..511 with load = 1. Then read 0..511 with load = 0 -> out = 16'h5A5A + i one cycle after each address; address 511 -> 16'h5C59.
3. Read-during-write: address = 9'h0A5, in = 16'hBEEF, load = 1 for one cycle -> out = 16'hBEEF on the next cycle. With load = 0, a re-read -> 16'hBEEF.
4. Fill request with concurrent load: in IDLE, fill_start = 1, fill_value = 16'hA5A5, plus load = 1 at address 3 with in = 16'h1234 in the same cycle.
   - busy rises; load and fill_start pulses during the fill are ignored.
   - After done, every address reads 16'hA5A5, including address 3.
5. Reset mid-fill: start a fill with fill_value = 16'hFFFF, assert rst_n low at fill cycle 100 for 2 cycles.
   - out = 0 and done = 0 immediately; busy stays 1.
   - After release, fill runs a full 512 cycles; all words read 16'h0000.
6. Override DATA_WIDTH = 8, ADDRESS_WIDTH = 3, FILL_VALUE = 8'h3C:
   - Post-reset busy lasts 8 cycles; all 8 words read 8'h3C.
   - Write 8'hFF at address 7, read back 8'hFF.
   - Address 0 still reads 8'h3C (no wrap corruption).
